rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of reset-synchronizer flops (minimum 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, the number of cycles the reset output is stretched (minimum 1).
REQ-003 SHALL have parameter CNT_W, default 8, the width of the soft-reset event counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: synchronous soft-reset request, sampled on the clk rising edge.
REQ-007 SHALL have port rst_out_n, output, 1 bit: sequenced reset to downstream logic, active low; asserts asynchronously and deasserts synchronously.
REQ-008 SHALL have port rst_busy, output, 1 bit: high while the sequencer is not in RUN.
REQ-009 SHALL have port sw_rst_ack, output, 1 bit: one-cycle pulse when a soft-reset sequence completes.
REQ-010 SHALL have port rst_cnt, output, CNT_W bits: saturating count of accepted soft resets.

Function
REQ-011 SHALL implement the state machine SYNC -> STRETCH -> RUN -> STRETCH, with one-hot or binary encoding taken from the package.
REQ-012 SYNC SHALL wait until the synchronizer output is 1, then move to STRETCH on the next edge with the stretch counter loaded to HOLD_CYCLES-1.
REQ-013 STRETCH SHALL decrement the stretch counter each cycle and move to RUN on the edge where the counter is 0.
REQ-014 rst_out_n SHALL be a registered output: 0 in SYNC and STRETCH, 1 in RUN.
REQ-015 Power-on timing: if rst_n rises before clk edge 1, rst_out_n SHALL rise at edge SYNC_STAGES+HOLD_CYCLES+1 (edge 7 with the default parameters).
REQ-016 In RUN, sw_rst_req=1 at edge t SHALL move to STRETCH at edge t, drive rst_out_n=0 from edge t, and drive rst_out_n=1 again at edge t+HOLD_CYCLES.
REQ-017 sw_rst_ack SHALL be 1 only during the cycle that follows a soft-reset-initiated STRETCH->RUN edge; it SHALL never pulse after the power-on sequence.
REQ-018 sw_rst_req while in SYNC or STRETCH, including on the final STRETCH edge, SHALL be ignored and SHALL NOT be queued.
REQ-019 sw_rst_req held continuously high SHALL restart the sequence on the first edge in RUN, giving exactly one RUN cycle between sequences.
REQ-020 rst_cnt SHALL increment by 1 on every accepted soft reset and SHALL saturate at all-ones.
REQ-021 rst_busy SHALL be combinationally equal to (state != RUN).

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, force: state=SYNC, synchronizer flops=0, rst_out_n=0, rst_busy=1, sw_rst_ack=0, rst_cnt=0, stretch counter=0.
REQ-023 rst_n assertion mid-STRETCH or in RUN SHALL abort the current sequence and discard the counter value; on release, full power-on timing (REQ-015) SHALL apply.

Configuration
REQ-024 Macro RST_SEQ_CNT_EN defined: the rst_cnt counter is implemented as in REQ-020.
REQ-025 Macro RST_SEQ_CNT_EN undefined: no counter flops are built and rst_cnt is tied to 0; all other behaviour is unchanged.

Structure
REQ-026 Package rst_seq_pkg SHALL hold the state encodings (ST_SYNC, ST_STRETCH, ST_RUN) and the default values for SYNC_STAGES, HOLD_CYCLES and CNT_W.
REQ-027 The synchronizer chain SHALL be a separate sub-module, sync_ff, parameterised by its number of stages, with asynchronous clear to 0.

Verification
REQ-028 Bench with CK_SEMIPERIOD=10 and rst_n released before edge 1 -> rst_out_n=0 through edge 6, rst_out_n=1 from edge 7, sw_rst_ack never pulses.
REQ-029 One-cycle sw_rst_req in RUN at edge t -> rst_out_n low for edges t..t+3, sw_rst_ack=1 for one cycle after edge t+4, rst_cnt=1.
REQ-030 sw_rst_req held high for 20 cycles -> back-to-back sequences separated by one RUN cycle; rst_cnt=4.
REQ-031 rst_n pulsed low mid-STRETCH, asynchronously between edges -> rst_out_n=0 and rst_cnt=0 immediately; power-on timing repeats after release.
REQ-032 CNT_W=2 with 5 accepted soft resets -> rst_cnt stays at 3; rebuild without RST_SEQ_CNT_EN -> rst_cnt=0 throughout.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// +--------------------------------------------------------------------+
// | rst_seq_pkg : state encodings and parameter defaults for rst_seq   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// +--------------------------------------------------------------------+
// | sync_ff : multi-stage synchronizer chain with asynchronous clear   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
// +--------------------------------------------------------------------+
// | rst_seq : reset sequencer (sync, stretch, soft-reset handling)     |
// | Optional macro RST_SEQ_CNT_EN builds the soft-reset event counter. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_rst_req,
  output logic             rst_out_n,
  output logic             rst_busy,
  output logic             sw_rst_ack,
  output logic [CNT_W-1:0] rst_cnt
);

  localparam int c_str_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_str_w-1:0] c_hold_load = c_str_w'(HOLD_CYCLES - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [c_str_w-1:0]   r_str_cnt;
  logic [c_str_w-1:0]   w_str_cnt_nxt;
  logic                 r_soft;
  logic                 w_soft_nxt;
  logic                 w_done;
  logic                 w_sync;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (1'b1),
    .q    (w_sync)
  );

  // r_soft remembers whether the current stretch came from a soft request,
  // so the power-on stretch never produces an ack.
  always_comb begin
    w_state_nxt   = r_state;
    w_str_cnt_nxt = r_str_cnt;
    w_soft_nxt    = r_soft;
    w_done        = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_sync) begin
          w_state_nxt   = ST_STRETCH;
          w_str_cnt_nxt = c_hold_load;
          w_soft_nxt    = 1'b0;
        end
      end
      ST_STRETCH: begin
        if (r_str_cnt == '0) begin
          w_state_nxt = ST_RUN;
          w_done      = 1'b1;
        end else begin
          w_str_cnt_nxt = r_str_cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (sw_rst_req) begin
          w_state_nxt   = ST_STRETCH;
          w_str_cnt_nxt = c_hold_load;
          w_soft_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SYNC;
      r_str_cnt  <= '0;
      r_soft     <= 1'b0;
      rst_out_n  <= 1'b0;
      sw_rst_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_str_cnt  <= w_str_cnt_nxt;
      r_soft     <= w_soft_nxt;
      rst_out_n  <= (w_state_nxt == ST_RUN);
      sw_rst_ack <= w_done & r_soft;
    end
  end

  assign rst_busy = (r_state != ST_RUN);

`ifdef RST_SEQ_CNT_EN
  logic             w_accept;
  logic [CNT_W-1:0] r_rst_cnt;

  assign w_accept = (r_state == ST_RUN) && sw_rst_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt <= '0;
    end else if (w_accept && (r_rst_cnt != '1)) begin
      r_rst_cnt <= r_rst_cnt + 1'b1;
    end
  end

  assign rst_cnt = r_rst_cnt;
`else
  assign rst_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// +--------------------------------------------------------------------+
// | tb_rst_seq : directed, table-driven self-checking bench for rst_seq|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int CK_SEMIPERIOD = 10;
`ifdef RST_SEQ_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sw_rst_req;
  logic       rst_out_n,  rst_busy,  sw_rst_ack;
  logic [7:0] rst_cnt;
  logic       rst_out_n2, rst_busy2, sw_rst_ack2;
  logic [1:0] rst_cnt2;

  int errors = 0;
  int checks = 0;

  rst_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst_req(sw_rst_req),
    .rst_out_n (rst_out_n),
    .rst_busy  (rst_busy),
    .sw_rst_ack(sw_rst_ack),
    .rst_cnt   (rst_cnt)
  );

  // Narrow-counter instance shares all inputs to exercise saturation
  rst_seq #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst_req(sw_rst_req),
    .rst_out_n (rst_out_n2),
    .rst_busy  (rst_busy2),
    .sw_rst_ack(sw_rst_ack2),
    .rst_cnt   (rst_cnt2)
  );

  initial clk = 1'b0;
  always #(CK_SEMIPERIOD) clk = ~clk;

  typedef struct {
    bit req;
    bit out_n;
    bit busy;
    bit ack;
    int cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit req);
    sw_rst_req = req;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input bit out_n, input bit busy,
                            input bit ack, input int cnt);
    check({tag, ".rst_out_n"},  int'(rst_out_n),  int'(out_n));
    check({tag, ".rst_busy"},   int'(rst_busy),   int'(busy));
    check({tag, ".sw_rst_ack"}, int'(sw_rst_ack), int'(ack));
    check({tag, ".rst_cnt"},    int'(rst_cnt),    cnt);
  endtask

  initial begin
    // Power-on sequence with ignored requests in SYNC/STRETCH, then a soft reset
    //            req out_n busy ack cnt
    tbl[0]  = '{0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, CNT_ON};
    tbl[9]  = '{0, 0, 1, 0, CNT_ON};
    tbl[10] = '{1, 0, 1, 0, CNT_ON};
    tbl[11] = '{0, 0, 1, 0, CNT_ON};
    tbl[12] = '{1, 1, 0, 1, CNT_ON};
    tbl[13] = '{0, 1, 0, 0, CNT_ON};
    tbl[14] = '{0, 1, 0, 0, CNT_ON};

    rst_n      = 1'b0;
    sw_rst_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outs("reset", 1'b0, 1'b1, 1'b0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req);
      check_outs($sformatf("tbl_edge%0d", i + 1), tbl[i].out_n, tbl[i].busy,
                 tbl[i].ack, tbl[i].cnt);
    end

    // Asynchronous reset in the middle of a soft-reset stretch
    step(1'b1);
    step(1'b0);
    check("pre_abort.rst_busy", int'(rst_busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check_outs("abort", 1'b0, 1'b1, 1'b0, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1'b0);
      check_outs($sformatf("repower_edge%0d", k), (k >= 7), (k < 7), 1'b0, 0);
    end

    // Request held high: one RUN cycle between back-to-back sequences
    for (int k = 0; k < 20; k++) begin
      step(1'b1);
      check($sformatf("hold%0d.rst_out_n", k), int'(rst_out_n), int'((k % 5) == 4));
      check($sformatf("hold%0d.sw_rst_ack", k), int'(sw_rst_ack), int'((k % 5) == 4));
    end
    step(1'b0);
    check_outs("hold_end", 1'b1, 1'b0, 1'b0, 4 * CNT_ON);

    // Fifth accepted soft reset: wide counter reaches 5, 2-bit counter saturates
    step(1'b1);
    check("fifth.rst_out_n", int'(rst_out_n), 0);
    for (int k = 0; k < 3; k++) step(1'b0);
    check("fifth_pre.rst_out_n", int'(rst_out_n), 0);
    step(1'b0);
    check_outs("fifth_done", 1'b1, 1'b0, 1'b1, 5 * CNT_ON);
    check("sat.rst_cnt2", int'(rst_cnt2), 3 * CNT_ON);
    check("sat.rst_out_n2", int'(rst_out_n2), 1);
    check("sat.sw_rst_ack2", int'(sw_rst_ack2), 1);
    step(1'b0);
    check_outs("after_fifth", 1'b1, 1'b0, 1'b0, 5 * CNT_ON);
    check("after_fifth.rst_busy2", int'(rst_busy2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
